// File: rtl/traffic_phase_ctrl.sv
// Two-direction traffic phase controller with pedestrian service and emergency preemption.
// All outputs are registered from next-state values so they track the state register exactly.
module traffic_phase_ctrl #(
  parameter int unsigned G_TIME     = 20,
  parameter int unsigned Y_TIME     = 2,
  parameter int unsigned AR_TIME    = 1,
  parameter int unsigned WALK_TIME  = 14,
  parameter int unsigned FLASH_TIME = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [3:0] i_ped_req,
  input  logic       i_emg_req,
  input  logic       i_emg_dir,
  output logic [1:0] o_ns_car,
  output logic [1:0] o_ew_car,
  output logic [1:0] o_ns_ped,
  output logic [1:0] o_ew_ped,
  output logic [2:0] o_state,
  output logic [6:0] o_timer,
  output logic [3:0] o_ped_pending,
  output logic       o_emg_ack
);

  localparam int unsigned TW = 7;
  localparam int unsigned EW = TW + 1;

  localparam logic [TW-1:0] G_LD  = TW'(G_TIME - 1);
  localparam logic [TW-1:0] Y_LD  = TW'(Y_TIME - 1);
  localparam logic [TW-1:0] AR_LD = TW'(AR_TIME - 1);
  localparam logic [EW-1:0] WALK_END  = EW'(WALK_TIME);
  localparam logic [EW-1:0] FLASH_END = EW'(WALK_TIME + FLASH_TIME);
  localparam logic          WALK_PAR  = WALK_TIME[0];

  localparam logic [1:0] CAR_GREEN  = 2'b01;
  localparam logic [1:0] CAR_YELLOW = 2'b10;
  localparam logic [1:0] CAR_RED    = 2'b11;
  localparam logic [1:0] PED_WALK   = 2'b01;
  localparam logic [1:0] PED_DONT   = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_NS_G    = 3'd1,
    ST_NS_Y    = 3'd2,
    ST_AR1     = 3'd3,
    ST_EW_G    = 3'd4,
    ST_EW_Y    = 3'd5,
    ST_AR2     = 3'd6,
    ST_PREEMPT = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    pending_q, pending_d, pend_set;
  logic          serve_ns_q, serve_ns_d;
  logic          serve_ew_q, serve_ew_d;
  logic          pre_dir_q, pre_dir_d;
  logic [1:0]    ns_car_q, ns_car_d, ew_car_q, ew_car_d;
  logic [1:0]    ns_ped_q, ns_ped_d, ew_ped_q, ew_ped_d;
  logic          emg_ack_q, emg_ack_d;
  logic [EW-1:0] elapsed;

  // Steady walk, then flashing starting on walk, then don't-walk.
  function automatic logic [1:0] ped_val(input logic served, input logic [EW-1:0] el);
    logic [1:0] v;
    v = PED_DONT;
    if (served) begin
      if (el < WALK_END)       v = PED_WALK;
      else if (el < FLASH_END) v = (el[0] == WALK_PAR) ? PED_WALK : PED_DONT;
    end
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      serve_ns_q <= 1'b0;
      serve_ew_q <= 1'b0;
      pre_dir_q  <= 1'b0;
      ns_car_q   <= CAR_RED;
      ew_car_q   <= CAR_RED;
      ns_ped_q   <= PED_DONT;
      ew_ped_q   <= PED_DONT;
      emg_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      serve_ns_q <= serve_ns_d;
      serve_ew_q <= serve_ew_d;
      pre_dir_q  <= pre_dir_d;
      ns_car_q   <= ns_car_d;
      ew_car_q   <= ew_car_d;
      ns_ped_q   <= ns_ped_d;
      ew_ped_q   <= ew_ped_d;
      emg_ack_q  <= emg_ack_d;
    end
  end

  // Next state, timer and pedestrian bookkeeping.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pre_dir_d  = pre_dir_q;
    pend_set   = pending_q | i_ped_req;
    pending_d  = pend_set;
    serve_ns_d = serve_ns_q;
    serve_ew_d = serve_ew_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_NS_G;
          timer_d = G_LD;
        end
      end
      ST_NS_G: begin
        if (i_start) begin
          if (i_emg_req && !i_emg_dir) begin
            state_d   = ST_PREEMPT;
            timer_d   = '0;
            pre_dir_d = 1'b0;
          end else if (i_emg_req || timer_q == '0) begin
            state_d = ST_NS_Y;
            timer_d = Y_LD;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end
      ST_NS_Y: begin
        if (i_start) begin
          if (timer_q == '0) begin
            state_d = ST_AR1;
            timer_d = AR_LD;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end
      ST_AR1: begin
        if (i_start) begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else if (i_emg_req) begin
            state_d   = ST_PREEMPT;
            timer_d   = '0;
            pre_dir_d = i_emg_dir;
          end else begin
            state_d = ST_EW_G;
            timer_d = G_LD;
          end
        end
      end
      ST_EW_G: begin
        if (i_start) begin
          if (i_emg_req && i_emg_dir) begin
            state_d   = ST_PREEMPT;
            timer_d   = '0;
            pre_dir_d = 1'b1;
          end else if (i_emg_req || timer_q == '0) begin
            state_d = ST_EW_Y;
            timer_d = Y_LD;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end
      ST_EW_Y: begin
        if (i_start) begin
          if (timer_q == '0) begin
            state_d = ST_AR2;
            timer_d = AR_LD;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end
      ST_AR2: begin
        if (i_start) begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else if (i_emg_req) begin
            state_d   = ST_PREEMPT;
            timer_d   = '0;
            pre_dir_d = i_emg_dir;
          end else begin
            state_d = ST_NS_G;
            timer_d = G_LD;
          end
        end
      end
      ST_PREEMPT: begin
        // Release clears through the all-red that leads to the other direction's green.
        if (!i_emg_req) begin
          state_d = pre_dir_q ? ST_AR2 : ST_AR1;
          timer_d = AR_LD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    // Cross-direction requests are captured into the serve flag on green entry.
    if (state_d == ST_EW_G && state_q != ST_EW_G) begin
      serve_ns_d     = |pend_set[3:2];
      pending_d[3:2] = 2'b00;
    end else if (state_d != ST_EW_G) begin
      serve_ns_d = 1'b0;
    end

    if (state_d == ST_NS_G && state_q != ST_NS_G) begin
      serve_ew_d     = |pend_set[1:0];
      pending_d[1:0] = 2'b00;
    end else if (state_d != ST_NS_G) begin
      serve_ew_d = 1'b0;
    end
  end

  // Output decode from next-state values, registered above.
  always_comb begin
    ns_car_d  = CAR_RED;
    ew_car_d  = CAR_RED;
    ns_ped_d  = PED_DONT;
    ew_ped_d  = PED_DONT;
    emg_ack_d = 1'b0;
    elapsed   = EW'(G_TIME - 1) - {1'b0, timer_d};

    unique case (state_d)
      ST_NS_G: begin
        ns_car_d = CAR_GREEN;
        ew_ped_d = ped_val(serve_ew_d, elapsed);
      end
      ST_NS_Y: ns_car_d = CAR_YELLOW;
      ST_EW_G: begin
        ew_car_d = CAR_GREEN;
        ns_ped_d = ped_val(serve_ns_d, elapsed);
      end
      ST_EW_Y: ew_car_d = CAR_YELLOW;
      ST_PREEMPT: begin
        emg_ack_d = 1'b1;
        if (pre_dir_d) ew_car_d = CAR_GREEN;
        else           ns_car_d = CAR_GREEN;
      end
      default: ;
    endcase
  end

  assign o_ns_car      = ns_car_q;
  assign o_ew_car      = ew_car_q;
  assign o_ns_ped      = ns_ped_q;
  assign o_ew_ped      = ew_ped_q;
  assign o_state       = state_q;
  assign o_timer       = timer_q;
  assign o_ped_pending = pending_q;
  assign o_emg_ack     = emg_ack_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed testbench for traffic_phase_ctrl with default timing parameters.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic [3:0] i_ped_req;
  logic       i_emg_req;
  logic       i_emg_dir;
  logic [1:0] o_ns_car, o_ew_car, o_ns_ped, o_ew_ped;
  logic [2:0] o_state;
  logic [6:0] o_timer;
  logic [3:0] o_ped_pending;
  logic       o_emg_ack;

  int checks = 0;
  int errors = 0;

  traffic_phase_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_ped_req     (i_ped_req),
    .i_emg_req     (i_emg_req),
    .i_emg_dir     (i_emg_dir),
    .o_ns_car      (o_ns_car),
    .o_ew_car      (o_ew_car),
    .o_ns_ped      (o_ns_ped),
    .o_ew_ped      (o_ew_ped),
    .o_state       (o_state),
    .o_timer       (o_timer),
    .o_ped_pending (o_ped_pending),
    .o_emg_ack     (o_emg_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_ped_req = 4'b0; i_emg_req = 1'b0; i_emg_dir = 1'b0;
    tick();
    checks++;
    if ({o_state, o_timer, o_ped_pending, o_emg_ack} !== {3'd0, 7'd0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL reset_regs: got st=%0d tm=%0d pend=%b ack=%b, exp 0/0/0000/0",
                         o_state, o_timer, o_ped_pending, o_emg_ack);
    end
    checks++;
    if ({o_ns_car, o_ew_car, o_ns_ped, o_ew_ped} !== 8'b1111_0000) begin
      errors++; $display("FAIL reset_outs: got %b%b%b%b, exp 11110000", o_ns_car, o_ew_car, o_ns_ped, o_ew_ped);
    end
  endtask

  // One full 46-cycle rotation from reset release, no requests.
  task automatic test_normal_cycle();
    logic [2:0] est[47];
    logic [6:0] etm[47];
    logic [1:0] ens, eew;
    int n = 0;
    for (int k = 19; k >= 0; k--) begin est[n] = 3'd1; etm[n] = 7'(k); n++; end
    est[n] = 3'd2; etm[n] = 7'd1; n++;
    est[n] = 3'd2; etm[n] = 7'd0; n++;
    est[n] = 3'd3; etm[n] = 7'd0; n++;
    for (int k = 19; k >= 0; k--) begin est[n] = 3'd4; etm[n] = 7'(k); n++; end
    est[n] = 3'd5; etm[n] = 7'd1; n++;
    est[n] = 3'd5; etm[n] = 7'd0; n++;
    est[n] = 3'd6; etm[n] = 7'd0; n++;
    est[n] = 3'd1; etm[n] = 7'd19;
    i_start = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < 47; i++) begin
      tick();
      ens = (est[i] == 3'd1) ? 2'b01 : (est[i] == 3'd2) ? 2'b10 : 2'b11;
      eew = (est[i] == 3'd4) ? 2'b01 : (est[i] == 3'd5) ? 2'b10 : 2'b11;
      checks++;
      if (o_state !== est[i] || o_timer !== etm[i]) begin
        errors++; $display("FAIL cycle_state[%0d]: got st=%0d tm=%0d, exp st=%0d tm=%0d",
                           i, o_state, o_timer, est[i], etm[i]);
      end
      checks++;
      if (o_ns_car !== ens || o_ew_car !== eew || o_ns_ped !== 2'b00 || o_ew_ped !== 2'b00) begin
        errors++; $display("FAIL cycle_outs[%0d]: got ns=%b ew=%b nsp=%b ewp=%b, exp ns=%b ew=%b peds 00",
                           i, o_ns_car, o_ew_car, o_ns_ped, o_ew_ped, ens, eew);
      end
    end
  endtask

  // North button in NS_G is served in the following EW_G.
  task automatic test_ped_service();
    logic [1:0] exp_p;
    int n = 0;
    i_ped_req = 4'b1000;
    tick();
    i_ped_req = 4'b0000;
    checks++;
    if (o_ped_pending !== 4'b1000) begin
      errors++; $display("FAIL ped_latch: got %b, exp 1000", o_ped_pending);
    end
    while (o_state !== 3'd4 && n < 60) begin tick(); n++; end
    checks++;
    if (o_state !== 3'd4) begin
      errors++; $display("FAIL ped_wait_ewg: got st=%0d, exp 4", o_state);
    end
    checks++;
    if (o_ped_pending !== 4'b0000) begin
      errors++; $display("FAIL ped_cleared: got %b, exp 0000", o_ped_pending);
    end
    for (int k = 0; k < 20; k++) begin
      if (k < 14) exp_p = 2'b01;
      else        exp_p = ((k - 14) % 2 == 0) ? 2'b01 : 2'b00;
      checks++;
      if (o_ns_ped !== exp_p || o_ew_ped !== 2'b00) begin
        errors++; $display("FAIL ped_walk[%0d]: got nsp=%b ewp=%b, exp nsp=%b ewp=00", k, o_ns_ped, o_ew_ped, exp_p);
      end
      tick();
    end
    checks++;
    if (o_state !== 3'd5 || o_ns_ped !== 2'b00) begin
      errors++; $display("FAIL ped_after: got st=%0d nsp=%b, exp st=5 nsp=00", o_state, o_ns_ped);
    end
  endtask

  // Dropping i_start freezes EW_G at timer 10; buttons still latch.
  task automatic test_freeze();
    int n = 0;
    while (!(o_state === 3'd4 && o_timer === 7'd10) && n < 100) begin tick(); n++; end
    checks++;
    if (o_state !== 3'd4 || o_timer !== 7'd10) begin
      errors++; $display("FAIL freeze_wait: got st=%0d tm=%0d, exp 4/10", o_state, o_timer);
    end
    i_start = 1'b0; i_ped_req = 4'b0001;
    tick();
    i_ped_req = 4'b0000;
    checks++;
    if (o_ped_pending !== 4'b0001) begin
      errors++; $display("FAIL freeze_latch: got %b, exp 0001", o_ped_pending);
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      checks++;
      if (o_state !== 3'd4 || o_timer !== 7'd10 || o_ew_car !== 2'b01 || o_ns_car !== 2'b11) begin
        errors++; $display("FAIL freeze_hold[%0d]: got st=%0d tm=%0d ew=%b ns=%b, exp 4/10/01/11",
                           k, o_state, o_timer, o_ew_car, o_ns_car);
      end
    end
    i_start = 1'b1;
    tick();
    checks++;
    if (o_timer !== 7'd9) begin
      errors++; $display("FAIL freeze_resume1: got %0d, exp 9", o_timer);
    end
    tick();
    checks++;
    if (o_timer !== 7'd8) begin
      errors++; $display("FAIL freeze_resume2: got %0d, exp 8", o_timer);
    end
  endtask

  // EW emergency during NS_G: yellow, all-red, PREEMPT, release via AR2.
  task automatic test_preempt_ew();
    int n = 0;
    while (!(o_state === 3'd1 && o_timer === 7'd15) && n < 100) begin tick(); n++; end
    checks++;
    if (o_state !== 3'd1 || o_timer !== 7'd15 || o_ew_ped !== 2'b01 || o_ped_pending !== 4'b0000) begin
      errors++; $display("FAIL pew_wait: got st=%0d tm=%0d ewp=%b pend=%b, exp 1/15/01/0000",
                         o_state, o_timer, o_ew_ped, o_ped_pending);
    end
    i_emg_req = 1'b1; i_emg_dir = 1'b1;
    tick();
    checks++;
    if (o_state !== 3'd2 || o_timer !== 7'd1 || o_ns_car !== 2'b10 || o_ew_ped !== 2'b00) begin
      errors++; $display("FAIL pew_yellow: got st=%0d tm=%0d ns=%b ewp=%b, exp 2/1/10/00",
                         o_state, o_timer, o_ns_car, o_ew_ped);
    end
    tick();
    checks++;
    if (o_state !== 3'd2 || o_timer !== 7'd0) begin
      errors++; $display("FAIL pew_yellow2: got st=%0d tm=%0d, exp 2/0", o_state, o_timer);
    end
    tick();
    checks++;
    if (o_state !== 3'd3 || o_ns_car !== 2'b11 || o_ew_car !== 2'b11) begin
      errors++; $display("FAIL pew_ar1: got st=%0d ns=%b ew=%b, exp 3/11/11", o_state, o_ns_car, o_ew_car);
    end
    tick();
    checks++;
    if ({o_state, o_timer, o_ew_car, o_ns_car, o_emg_ack} !== {3'd7, 7'd0, 2'b01, 2'b11, 1'b1}) begin
      errors++; $display("FAIL pew_preempt: got st=%0d tm=%0d ew=%b ns=%b ack=%b, exp 7/0/01/11/1",
                         o_state, o_timer, o_ew_car, o_ns_car, o_emg_ack);
    end
    i_start = 1'b0;
    tick();
    checks++;
    if (o_state !== 3'd7 || o_ns_ped !== 2'b00 || o_ew_ped !== 2'b00) begin
      errors++; $display("FAIL pew_hold: got st=%0d nsp=%b ewp=%b, exp 7/00/00", o_state, o_ns_ped, o_ew_ped);
    end
    i_start = 1'b1; i_emg_req = 1'b0;
    tick();
    checks++;
    if (o_state !== 3'd6 || o_emg_ack !== 1'b0 || o_ew_car !== 2'b11) begin
      errors++; $display("FAIL pew_ar2: got st=%0d ack=%b ew=%b, exp 6/0/11", o_state, o_emg_ack, o_ew_car);
    end
    tick();
    checks++;
    if (o_state !== 3'd1 || o_timer !== 7'd19) begin
      errors++; $display("FAIL pew_nsg: got st=%0d tm=%0d, exp 1/19", o_state, o_timer);
    end
  endtask

  // NS emergency in NS_G: immediate PREEMPT; requests retained; entry-edge press served.
  task automatic test_preempt_ns();
    int n = 0;
    i_ped_req = 4'b0010;
    tick();
    i_ped_req = 4'b0000;
    checks++;
    if (o_ped_pending !== 4'b0010) begin
      errors++; $display("FAIL pns_latch: got %b, exp 0010", o_ped_pending);
    end
    while (!(o_state === 3'd1 && o_timer === 7'd19) && n < 100) begin tick(); n++; end
    checks++;
    if (o_state !== 3'd1 || o_ew_ped !== 2'b01 || o_ped_pending !== 4'b0000) begin
      errors++; $display("FAIL pns_serve: got st=%0d ewp=%b pend=%b, exp 1/01/0000", o_state, o_ew_ped, o_ped_pending);
    end
    tick(); tick();
    checks++;
    if (o_timer !== 7'd17 || o_ew_ped !== 2'b01) begin
      errors++; $display("FAIL pns_walk: got tm=%0d ewp=%b, exp 17/01", o_timer, o_ew_ped);
    end
    i_emg_req = 1'b1; i_emg_dir = 1'b0;
    tick();
    checks++;
    if ({o_state, o_timer, o_ns_car, o_ew_car, o_ew_ped, o_emg_ack} !== {3'd7, 7'd0, 2'b01, 2'b11, 2'b00, 1'b1}) begin
      errors++; $display("FAIL pns_preempt: got st=%0d tm=%0d ns=%b ew=%b ewp=%b ack=%b, exp 7/0/01/11/00/1",
                         o_state, o_timer, o_ns_car, o_ew_car, o_ew_ped, o_emg_ack);
    end
    i_ped_req = 4'b1000;
    tick();
    i_ped_req = 4'b0000;
    checks++;
    if (o_state !== 3'd7 || o_ped_pending !== 4'b1000) begin
      errors++; $display("FAIL pns_pend: got st=%0d pend=%b, exp 7/1000", o_state, o_ped_pending);
    end
    i_emg_req = 1'b0;
    tick();
    checks++;
    if (o_state !== 3'd3 || o_emg_ack !== 1'b0 || o_ns_car !== 2'b11 || o_ped_pending !== 4'b1000) begin
      errors++; $display("FAIL pns_ar1: got st=%0d ack=%b ns=%b pend=%b, exp 3/0/11/1000",
                         o_state, o_emg_ack, o_ns_car, o_ped_pending);
    end
    i_ped_req = 4'b0100;
    tick();
    i_ped_req = 4'b0000;
    checks++;
    if ({o_state, o_timer, o_ped_pending, o_ns_ped, o_ew_car} !== {3'd4, 7'd19, 4'b0000, 2'b01, 2'b01}) begin
      errors++; $display("FAIL pns_ewg: got st=%0d tm=%0d pend=%b nsp=%b ew=%b, exp 4/19/0000/01/01",
                         o_state, o_timer, o_ped_pending, o_ns_ped, o_ew_car);
    end
  endtask

  // Asynchronous reset in EW_Y discards pending requests; IDLE waits for i_start.
  task automatic test_reset_mid();
    int n = 0;
    i_ped_req = 4'b1111;
    tick();
    i_ped_req = 4'b0000;
    while (o_state !== 3'd5 && n < 60) begin tick(); n++; end
    checks++;
    if (o_state !== 3'd5 || o_ped_pending !== 4'b1111) begin
      errors++; $display("FAIL rmid_pre: got st=%0d pend=%b, exp 5/1111", o_state, o_ped_pending);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_state, o_timer, o_ped_pending, o_ns_car, o_ew_car, o_emg_ack} !== {3'd0, 7'd0, 4'd0, 2'b11, 2'b11, 1'b0}) begin
      errors++; $display("FAIL rmid_async: got st=%0d tm=%0d pend=%b ns=%b ew=%b ack=%b, exp 0/0/0000/11/11/0",
                         o_state, o_timer, o_ped_pending, o_ns_car, o_ew_car, o_emg_ack);
    end
    i_start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (o_state !== 3'd0 || o_timer !== 7'd0) begin
      errors++; $display("FAIL rmid_idle: got st=%0d tm=%0d, exp 0/0", o_state, o_timer);
    end
    i_start = 1'b1;
    tick();
    checks++;
    if (o_state !== 3'd1 || o_timer !== 7'd19 || o_ns_car !== 2'b01) begin
      errors++; $display("FAIL rmid_start: got st=%0d tm=%0d ns=%b, exp 1/19/01", o_state, o_timer, o_ns_car);
    end
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_ped_service();
    test_freeze();
    test_preempt_ew();
    test_preempt_ns();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 SHALL have parameter G_TIME, default 20: green duration in enabled cycles.
REQ-002 SHALL have parameter Y_TIME, default 2: yellow duration in enabled cycles.
REQ-003 SHALL have parameter AR_TIME, default 1: all-red clearance duration in enabled cycles.
REQ-004 SHALL have parameter WALK_TIME, default 14: pedestrian steady-walk cycles; parameter FLASH_TIME, default 6: flashing-walk cycles; WALK_TIME+FLASH_TIME <= G_TIME is a legal-configuration constraint.
REQ-005 clk  input  1  clock; all state changes occur on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_start  input  1  run enable; low freezes sequencing.
REQ-008 i_ped_req  input  4  pedestrian buttons {n,s,e,w} at bits [3:0].
REQ-009 i_emg_req  input  1  emergency preemption request, level, held by requester.
REQ-010 i_emg_dir  input  1  preempt direction: 0 = NS, 1 = EW; sampled while i_emg_req=1.
REQ-011 o_ns_car, o_ew_car  output  2 each  car signal: 01 green, 10 yellow, 11 red.
REQ-012 o_ns_ped, o_ew_ped  output  2 each  pedestrian signal: 01 walk, 00 don't-walk.
REQ-013 o_state  output  3  current FSM state encoding (REQ-016).
REQ-014 o_timer  output  7  remaining cycles in current timed state.
REQ-015 o_ped_pending  output  4  latched, not-yet-served pedestrian requests; o_emg_ack  output  1  high while in PREEMPT.

Function
REQ-016 FSM states SHALL be IDLE=0, NS_G=1, NS_Y=2, AR1=3, EW_G=4, EW_Y=5, AR2=6, PREEMPT=7.
REQ-017 Normal order SHALL be IDLE -> NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> NS_G; with defaults one full cycle is 46 enabled cycles.
REQ-018 IDLE SHALL move to NS_G on the first edge with i_start=1.
REQ-019 On entry to a timed state, o_timer SHALL load duration-1; it decrements each edge with i_start=1; the state exits on the edge where o_timer=0 and i_start=1.
REQ-020 With i_start=0: state, o_timer, and flash phase SHALL hold; button latching continues.
REQ-021 Car outputs: the green-phase direction SHALL show 01 in *_G and 10 in *_Y; all other directions and states show 11, except PREEMPT (REQ-027).
REQ-022 Button press SHALL set the matching o_ped_pending bit and hold it until served.
REQ-023 NS pedestrians (n,s) SHALL be served in EW_G; EW pedestrians (e,w) SHALL be served in NS_G.
REQ-024 On green entry, the cross-direction pending bits SHALL be copied into a serve flag and cleared; a press on the entry edge counts as served.
REQ-025 Service timing while served, with elapsed e = G_TIME-1-o_timer:
- e in 0..WALK_TIME-1: ped = 01.
- e in WALK_TIME..WALK_TIME+FLASH_TIME-1: ped alternates 01, 00, 01, ..., starting at 01.
- otherwise: ped = 00.
Unserved pedestrians SHALL stay 00.
REQ-026 i_emg_req=1 in the opposite direction's green SHALL force the next state to that direction's yellow, then all-red, then PREEMPT. In yellow or all-red, the current state finishes normally, then goes to PREEMPT. In the requested direction's own green, the FSM goes to PREEMPT on the next edge.
REQ-027 PREEMPT outputs:
- requested direction car = 01, other direction car = 11.
- both ped outputs = 00.
- o_timer = 0.
- o_emg_ack = 1.
PREEMPT SHALL hold while i_emg_req=1, regardless of i_start.
REQ-028 On release, PREEMPT SHALL go to all-red for AR_TIME cycles (AR1 if NS was preempted, else AR2), then to the green of the other direction; pending requests SHALL be retained throughout.
REQ-029 Ped outputs SHALL drop to 00 on the edge an emergency forces a green to yellow.
REQ-030 Outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-031 While rst_n=0, all of the following SHALL hold:
- state = IDLE, o_state = 0.
- both car outputs = 11, both ped outputs = 00.
- o_timer = 0, o_ped_pending = 0, o_emg_ack = 0.
- serve flags and flash phase cleared.
REQ-032 Reset asserted mid-operation SHALL take effect immediately and discard pending requests; after release the FSM waits in IDLE for i_start.

Verification
REQ-033 Release reset with i_start=1, no requests -> NS_G with o_timer 19..0, NS_Y 2 cycles, AR1 1 cycle, EW_G 20 cycles; next NS_G begins 46 cycles after the first NS_G entry; peds stay 00.
REQ-034 Press n during NS_G -> pending[3]=1; at EW_G entry pending[3]=0; o_ns_ped = 01 for 14 cycles, alternates 01/00 for 6 cycles, then 00.
REQ-035 Drop i_start for 5 cycles in EW_G at o_timer=10 -> o_timer stays 10, outputs frozen; resumes 9, 8, ... when i_start returns.
REQ-036 i_emg_req=1, i_emg_dir=1 during NS_G at o_timer=15 -> NS_Y 2 cycles, AR1 1 cycle, PREEMPT with ew_car=01 and o_emg_ack=1; release -> AR2 1 cycle -> NS_G.
REQ-037 Assert rst_n=0 in EW_Y with pending=4'b1111 -> immediately IDLE, all cars 11, pending 0.
REQ-038 i_emg_req=1, i_emg_dir=0 during NS_G -> PREEMPT on the next edge with ns_car held at 01, and any walking EW ped drops to 00.
